ppu_operand_stage: RTL and testbench

- Registered front-end stage directly upstream of the posit add/sub datapath.
- Accepts an operand pair plus an add/sub opcode through a valid/ready handshake.
- Negates in2 for subtraction, then decodes both posits into sign, scale and mantissa, and detects zero/NaR.
- Orders the two lanes by magnitude and presents them to the adder core through a 2-entry elastic buffer, giving full throughput under backpressure.

---
 rtl/ppu_pkg.sv | 38 +++
 rtl/posit_decode.sv | 76 +++++++
 rtl/ppu_operand_stage.sv | 148 ++++++++++++++
 tb/tb_ppu_operand_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ----------------------------------------------------------------------------
// ppu_pkg
// Shared constants and types for the posit add/sub operand front end.
//   POSIT_N / POSIT_ES : default posit width and exponent field width
//   Bs                 : bits needed to index a posit bit position
//   SW                 : width of the signed scale (k*2^es + e)
//   FW                 : fraction width; mantissa is {hidden, fraction}
//   posit_fields_t     : one decoded operand lane
//   pair_t             : one ordered operand pair as held in the stage buffer
//   nar_value()        : the Not-a-Real bit pattern (1 followed by zeros)
// ----------------------------------------------------------------------------
package ppu_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 2;
    localparam int Bs       = $clog2(POSIT_N);
    localparam int SW       = Bs + POSIT_ES + 1;
    localparam int FW       = POSIT_N - POSIT_ES - 3;

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic          nar;
        logic [SW-1:0] scale;
        logic [FW:0]   mant;
    } posit_fields_t;

    typedef struct packed {
        posit_fields_t a;
        posit_fields_t b;
        logic          swap;
    } pair_t;

    function automatic logic [POSIT_N-1:0] nar_value();
        return {1'b1, {(POSIT_N-1){1'b0}}};
    endfunction

endpackage

// File: rtl/posit_decode.sv
// ----------------------------------------------------------------------------
// posit_decode
// Combinational posit field extractor.
//   i_posit : raw posit (two's complement encoding)
//   o_sign  : sign bit as presented
//   o_zero  : operand is exact zero
//   o_nar   : operand is NaR
//   o_scale : signed k*2^ES + e (0 for zero/NaR)
//   o_mant  : {1, fraction} left-aligned (0 for zero/NaR)
//   o_mag   : low N-1 bits of |i_posit|, used for magnitude ordering
// ----------------------------------------------------------------------------
module posit_decode #(
    parameter int N  = 32,
    parameter int ES = 2,
    localparam int BS = $clog2(N),
    localparam int SW = BS + ES + 1,
    localparam int FW = N - ES - 3
) (
    input  logic [N-1:0]  i_posit,
    output logic          o_sign,
    output logic          o_zero,
    output logic          o_nar,
    output logic [SW-1:0] o_scale,
    output logic [FW:0]   o_mant,
    output logic [N-2:0]  o_mag
);

    logic [N-2:0]         w_mag;
    logic                 w_rbit;
    logic [N-2:0]         w_run_bits;
    logic [BS:0]          w_run;
    logic                 w_found;
    logic [ES+FW-1:0]     w_rem;
    logic signed [SW-1:0] w_run_s;
    logic signed [SW-1:0] w_k;

    always_comb begin
        o_sign = i_posit[N-1];
        o_zero = (i_posit == '0);
        o_nar  = (i_posit == {1'b1, {(N-1){1'b0}}});

        // Only the N-1 magnitude bits matter; the borrow into the MSB is
        // irrelevant because the sign has already been captured.
        w_mag  = o_sign ? (~i_posit[N-2:0] + 1'b1) : i_posit[N-2:0];
        w_rbit = w_mag[N-2];

        // Invert a run of 1s so the regime run length is a leading-zero count.
        w_run_bits = w_rbit ? ~w_mag : w_mag;
        w_run      = (BS+1)'(N-1);
        w_found    = 1'b0;
        for (int i = N-2; i >= 0; i--) begin
            if (!w_found && w_run_bits[i]) begin
                w_run   = (BS+1)'(N-2-i);
                w_found = 1'b1;
            end
        end

        // The run is never shorter than 1, so dropping regime + terminator
        // (run+1 bits) is the same as shifting the body below the first two
        // regime bits by run-1. Bits falling off the end zero-fill e/frac.
        w_rem = w_mag[N-4:0] << (w_run - 1'b1);

        w_run_s = SW'(w_run);
        w_k     = w_rbit ? (w_run_s - SW'(1)) : -w_run_s;

        o_mag = w_mag;
        if (o_zero || o_nar) begin
            o_scale = '0;
            o_mant  = '0;
        end else begin
            o_scale = SW'(w_k <<< ES) + SW'(w_rem[ES+FW-1 -: ES]);
            o_mant  = {1'b1, w_rem[FW-1:0]};
        end
    end

endmodule

// File: rtl/ppu_operand_stage.sv
// ----------------------------------------------------------------------------
// ppu_operand_stage
// Registered operand front end for the posit add/sub core.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous clear of both buffer entries
//   in_valid/in_ready     : input handshake (in_ready is registered)
//   in_op_sub             : 1 = in1 - in2
//   in1, in2, in_tag      : operands and passthrough tag
//   out_valid/out_ready   : output handshake
//   out_*_a / out_*_b     : decoded lanes, A = larger magnitude
//   out_nar, out_eff_sub  : either operand NaR, lane signs differ
//   out_swap, out_tag     : lane A came from in2, tag of the pair
// Decoded pairs pass through a primary output register backed by one skid
// entry so that in_ready can be a flop and throughput stays at one pair
// per cycle under backpressure.
// ----------------------------------------------------------------------------
module ppu_operand_stage
    import ppu_pkg::*;
#(
    parameter int N     = POSIT_N,
    parameter int es    = POSIT_ES,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op_sub,
    input  logic [N-1:0]     in1,
    input  logic [N-1:0]     in2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign_a,
    output logic             out_sign_b,
    output logic [SW-1:0]    out_scale_a,
    output logic [SW-1:0]    out_scale_b,
    output logic [FW:0]      out_mant_a,
    output logic [FW:0]      out_mant_b,
    output logic             out_zero_a,
    output logic             out_zero_b,
    output logic             out_nar,
    output logic             out_eff_sub,
    output logic             out_swap,
    output logic [TAG_W-1:0] out_tag
);

    logic [N-1:0]   w_operand [2];
    posit_fields_t  w_fields  [2];
    logic [N-2:0]   w_mag     [2];
    pair_t          w_pair;
    logic           w_swap;
    logic           w_push;
    logic           w_pop;

    pair_t            r_prim;
    pair_t            r_skid;
    logic [TAG_W-1:0] r_prim_tag;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_prim_valid;
    logic             r_skid_valid;
    logic             r_in_ready;

    // Subtraction negates in2; 0 and NaR are their own negation.
    assign w_operand[0] = in1;
    assign w_operand[1] = in_op_sub ? (~in2 + 1'b1) : in2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            posit_decode #(
                .N  (N),
                .ES (es)
            ) u_dec (
                .i_posit (w_operand[gi]),
                .o_sign  (w_fields[gi].sign),
                .o_zero  (w_fields[gi].zero),
                .o_nar   (w_fields[gi].nar),
                .o_scale (w_fields[gi].scale),
                .o_mant  (w_fields[gi].mant),
                .o_mag   (w_mag[gi])
            );
        end
    endgenerate

    // Strict compare so that ties leave in1 in lane A.
    assign w_swap      = (w_mag[1] > w_mag[0]);
    assign w_pair.a    = w_swap ? w_fields[1] : w_fields[0];
    assign w_pair.b    = w_swap ? w_fields[0] : w_fields[1];
    assign w_pair.swap = w_swap;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_prim_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prim       <= '0;
            r_skid       <= '0;
            r_prim_tag   <= '0;
            r_skid_tag   <= '0;
            r_prim_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_prim_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_prim_valid || w_pop) begin
            // Primary is free this edge: refill from skid first (order),
            // otherwise from the input. No push can coincide with a full
            // skid because in_ready is low then.
            if (r_skid_valid) begin
                r_prim       <= r_skid;
                r_prim_tag   <= r_skid_tag;
                r_prim_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_push) begin
                r_prim       <= w_pair;
                r_prim_tag   <= in_tag;
                r_prim_valid <= 1'b1;
            end else begin
                r_prim_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_skid       <= w_pair;
            r_skid_tag   <= in_tag;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_prim_valid;
    assign out_sign_a  = r_prim.a.sign;
    assign out_sign_b  = r_prim.b.sign;
    assign out_scale_a = r_prim.a.scale;
    assign out_scale_b = r_prim.b.scale;
    assign out_mant_a  = r_prim.a.mant;
    assign out_mant_b  = r_prim.b.mant;
    assign out_zero_a  = r_prim.a.zero;
    assign out_zero_b  = r_prim.b.zero;
    assign out_nar     = r_prim.a.nar | r_prim.b.nar;
    assign out_eff_sub = r_prim.a.sign ^ r_prim.b.sign;
    assign out_swap    = r_prim.swap;
    assign out_tag     = r_prim_tag;

endmodule

// File: tb/tb_ppu_operand_stage.sv
module tb_ppu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_op_sub;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign_a, out_sign_b;
    logic [7:0]  out_scale_a, out_scale_b;
    logic [27:0] out_mant_a, out_mant_b;
    logic        out_zero_a, out_zero_b;
    logic        out_nar, out_eff_sub, out_swap;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ppu_operand_stage #(.N(32), .es(2), .TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_sub   (in_op_sub),
        .in1         (in1),
        .in2         (in2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign_a  (out_sign_a),
        .out_sign_b  (out_sign_b),
        .out_scale_a (out_scale_a),
        .out_scale_b (out_scale_b),
        .out_mant_a  (out_mant_a),
        .out_mant_b  (out_mant_b),
        .out_zero_a  (out_zero_a),
        .out_zero_b  (out_zero_b),
        .out_nar     (out_nar),
        .out_eff_sub (out_eff_sub),
        .out_swap    (out_swap),
        .out_tag     (out_tag)
    );

    // ------------------------------------------------------------------
    // Reference model: walk the posit bit string as the format describes.
    // ------------------------------------------------------------------
    typedef struct {
        logic        sign;
        logic        zero;
        logic        nar;
        logic [7:0]  scale;
        logic [27:0] mant;
        logic [30:0] mag;
    } dec_t;

    typedef struct {
        logic        sa, sb;
        logic [7:0]  sca, scb;
        logic [27:0] ma, mb;
        logic        za, zb, nar, eff, swap;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];

    function automatic dec_t model_decode(input logic [31:0] p);
        dec_t        d;
        logic [31:0] a;
        logic [26:0] frac;
        logic        r;
        int          idx, m, k, e;
        d.sign  = p[31];
        d.zero  = (p == 32'h0);
        d.nar   = (p == 32'h8000_0000);
        a       = p[31] ? (32'd0 - p) : p;
        d.mag   = a[30:0];
        d.scale = 8'h0;
        d.mant  = 28'h0;
        if (!d.zero && !d.nar) begin
            idx = 30;
            r   = a[30];
            m   = 0;
            while (idx >= 0 && a[idx] == r) begin
                m++;
                idx--;
            end
            k = r ? (m - 1) : -m;
            idx--;
            e = 0;
            repeat (2) begin
                e = e * 2 + ((idx >= 0) ? int'(a[idx]) : 0);
                idx--;
            end
            frac = '0;
            repeat (27) begin
                frac = {frac[25:0], (idx >= 0) ? a[idx] : 1'b0};
                idx--;
            end
            d.scale = 8'(k * 4 + e);
            d.mant  = {1'b1, frac};
        end
        return d;
    endfunction

    function automatic exp_t model_pair(input logic sub, input logic [31:0] x,
                                        input logic [31:0] y, input logic [3:0] tag);
        exp_t x_e;
        dec_t d1, d2, da, db;
        d1 = model_decode(x);
        d2 = model_decode(sub ? (32'd0 - y) : y);
        x_e.swap = (d2.mag > d1.mag);
        da = x_e.swap ? d2 : d1;
        db = x_e.swap ? d1 : d2;
        x_e.sa  = da.sign;  x_e.sb  = db.sign;
        x_e.sca = da.scale; x_e.scb = db.scale;
        x_e.ma  = da.mant;  x_e.mb  = db.mant;
        x_e.za  = da.zero;  x_e.zb  = db.zero;
        x_e.nar = da.nar | db.nar;
        x_e.eff = da.sign ^ db.sign;
        x_e.tag = tag;
        return x_e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: checks on the falling edge, then advances the model
    // for the coming rising edge using the inputs that edge will see.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_data_zero", 32'(|{out_sign_a, out_sign_b, out_scale_a, out_scale_b,
                                      out_mant_a, out_mant_b, out_zero_a, out_zero_b,
                                      out_nar, out_eff_sub, out_swap, out_tag}), 32'd0);
        end else begin
            bit can_push, do_pop;
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0 && out_valid) begin
                chk("sign_a", 32'(out_sign_a), 32'(q[0].sa));
                chk("sign_b", 32'(out_sign_b), 32'(q[0].sb));
                chk("scale_a", 32'(out_scale_a), 32'(q[0].sca));
                chk("scale_b", 32'(out_scale_b), 32'(q[0].scb));
                chk("mant_a", 32'(out_mant_a), 32'(q[0].ma));
                chk("mant_b", 32'(out_mant_b), 32'(q[0].mb));
                chk("zero_a", 32'(out_zero_a), 32'(q[0].za));
                chk("zero_b", 32'(out_zero_b), 32'(q[0].zb));
                chk("nar", 32'(out_nar), 32'(q[0].nar));
                chk("eff_sub", 32'(out_eff_sub), 32'(q[0].eff));
                chk("swap", 32'(out_swap), 32'(q[0].swap));
                chk("tag", 32'(out_tag), 32'(q[0].tag));
                $display("xfer tag=%0d sa=%0b sca=%0h sb=%0b scb=%0h swap=%0b nar=%0b ready=%0b",
                         out_tag, out_sign_a, out_scale_a, out_sign_b, out_scale_b,
                         out_swap, out_nar, out_ready);
            end
            can_push = (q.size() < 2);
            do_pop   = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (in_valid && can_push) q.push_back(model_pair(in_op_sub, in1, in2, in_tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for one cycle with an empty, ready stage and leave
    // the bench at the falling edge where that pair is on the outputs.
    task automatic send_one(input logic sub, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] tag);
        in_valid  = 1'b1;
        in_op_sub = sub;
        in1       = x;
        in2       = y;
        in_tag    = tag;
        step();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] vec_a [8];
    logic [31:0] vec_b [8];
    logic [3:0]  seen  [3];
    dec_t        md;

    initial begin
        vec_a = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hC000_0000,
                  32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3F00_0001};
        vec_b = '{32'h4800_0000, 32'h0000_0001, 32'hA000_0000, 32'h4000_0000,
                  32'hEDCB_A988, 32'h0000_0000, 32'h5000_0000, 32'h3F00_0001};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op_sub = 1'b0;
        in1 = '0; in2 = '0; in_tag = '0; out_ready = 1'b1;

        // Pin the model against hand-decoded values.
        md = model_decode(32'h4800_0000);
        chk("model_4800_scale", 32'(md.scale), 32'h01);
        chk("model_4800_mant", 32'(md.mant), 32'h800_0000);
        md = model_decode(32'h0000_0001);
        chk("model_0001_scale", 32'(md.scale), 32'h88);
        md = model_decode(32'hA000_0000);
        chk("model_A000_scale", 32'(md.scale), 32'h04);
        chk("model_A000_sign", 32'(md.sign), 32'd1);
        md = model_decode(32'h5000_0000);
        chk("model_5000_scale_mant", {20'(md.scale), 12'(md.mant >> 16)}, {20'h2, 12'h800});

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Directed pairs with literal expectations.
        send_one(1'b0, 32'h4000_0000, 32'h4800_0000, 4'd1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_scale_a", 32'(out_scale_a), 32'h01);
        chk("t1_scale_b", 32'(out_scale_b), 32'h00);
        chk("t1_mant_a", 32'(out_mant_a), 32'h800_0000);
        chk("t1_mant_b", 32'(out_mant_b), 32'h800_0000);
        chk("t1_swap", 32'(out_swap), 32'd1);
        chk("t1_eff_sub", 32'(out_eff_sub), 32'd0);

        send_one(1'b1, 32'h4000_0000, 32'h4000_0000, 4'd2);
        chk("t2_sign_a", 32'(out_sign_a), 32'd0);
        chk("t2_sign_b", 32'(out_sign_b), 32'd1);
        chk("t2_eff_sub", 32'(out_eff_sub), 32'd1);
        chk("t2_swap", 32'(out_swap), 32'd0);
        chk("t2_scales", {16'(out_scale_a), 16'(out_scale_b)}, 32'h0);

        send_one(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3);
        chk("t3_scale_a", 32'(out_scale_a), 32'h78);
        chk("t3_scale_b", 32'(out_scale_b), 32'h88);
        chk("t3_mant_a", 32'(out_mant_a), 32'h800_0000);
        chk("t3_mant_b", 32'(out_mant_b), 32'h800_0000);

        send_one(1'b0, 32'h8000_0000, 32'h6000_0000, 4'd4);
        chk("t4_nar", 32'(out_nar), 32'd1);

        send_one(1'b0, 32'h0000_0000, 32'hA000_0000, 4'd5);
        chk("t5_sign_a", 32'(out_sign_a), 32'd1);
        chk("t5_scale_a", 32'(out_scale_a), 32'h04);
        chk("t5_swap", 32'(out_swap), 32'd1);
        chk("t5_zero_b", 32'(out_zero_b), 32'd1);
        chk("t5_zero_a", 32'(out_zero_a), 32'd0);
        step();

        // Backpressure: tags 1,2 fill the buffer, tag 3 waits at the input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op_sub = 1'b0; in1 = 32'h4000_0000; in2 = 32'h2000_0000;
        for (int t = 1; t <= 3; t++) begin
            in_tag = 4'(t);
            step();
        end
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_head_tag", 32'(out_tag), 32'd1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = out_valid ? out_tag : 4'hF;
            step();
            if (i == 1) in_valid = 1'b0;
        end
        chk("bp_order", {20'h0, seen[0], seen[1], seen[2]}, 32'h123);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        step();

        // Reset while two pairs are held.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_tag = 4'd5; step();
        in_tag = 4'd6; step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(); step();
        @(negedge clk);
        chk("rst_no_stale", 32'(out_valid), 32'd0);
        step();

        // Flush while two pairs are held: effective at the next edge.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_tag = 4'd7; step();
        in_tag = 4'd8; step();
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_before_edge", 32'(out_valid), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        step();

        // Flush wins over a simultaneous push.
        in_valid = 1'b1; in_tag = 4'd10; step();
        in_tag = 4'd11; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_drops_push", 32'(out_valid), 32'd0);
        step();

        // Mixed stream with irregular valid/ready; the compare process
        // checks every cycle against the model.
        for (int i = 0; i < 32; i++) begin
            in_valid  = ((i % 5) != 3);
            out_ready = ((i % 7) < 4);
            in_op_sub = i[0];
            in1       = vec_a[i % 8];
            in2       = vec_b[(i + i / 8) % 8];
            in_tag    = 4'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
